// File: rtl/win_checker_pkg.sv
// win_checker_pkg: shared definitions for the tic-tac-toe board checker.
//   - cell_t      : internal 2-bit cell code (empty / X / O)
//   - winner_t    : winner report code (none / X / O / both)
//   - LINE_TBL    : the 8 winning lines as cell indices (rows, cols, diags)
//   - decode_cell : maps a 16-bit RAM word onto a cell code
// Optional feature macro used by the checker: WIN_CHECK_ILLEGAL_EN.
package win_checker_pkg;

  localparam int unsigned NUM_CELLS = 9;
  localparam int unsigned NUM_LINES = 8;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'b00,
    CELL_X     = 2'b01,
    CELL_O     = 2'b10
  } cell_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_X    = 2'b01,
    WIN_O    = 2'b10,
    WIN_BOTH = 2'b11
  } winner_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EVAL
  } state_t;

  localparam logic [3:0]  WIN_LINE_NONE = 4'd15;

  // RAM word encodings for a cell
  localparam logic [15:0] RAM_EMPTY = 16'h0000;
  localparam logic [15:0] RAM_X     = 16'h0001;
  localparam logic [15:0] RAM_O     = 16'h0002;

  // Line index -> the three cell indices it covers (row-major board)
  localparam int unsigned LINE_TBL [NUM_LINES][3] = '{
    '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},   // rows
    '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},   // columns
    '{0, 4, 8}, '{2, 4, 6}                // diagonals
  };

  function automatic cell_t decode_cell(input logic [15:0] word);
    cell_t c;
    c = CELL_EMPTY;
    if (word == RAM_X) begin
      c = CELL_X;
    end else if (word == RAM_O) begin
      c = CELL_O;
    end
    return c;
  endfunction

  // True for the three encodings a well-formed board may contain
  function automatic logic is_valid_word(input logic [15:0] word);
    return (word == RAM_EMPTY) || (word == RAM_X) || (word == RAM_O);
  endfunction

endpackage

// File: rtl/win_checker_line_eval.sv
// win_line_eval: combinational test of one tic-tac-toe line.
// Ports:
//   c0, c1, c2 : the three cell codes on the line (cell_t encoding)
//   x_win      : all three cells are X
//   o_win      : all three cells are O
module win_line_eval
  import win_checker_pkg::*;
(
  input  logic [1:0] c0,
  input  logic [1:0] c1,
  input  logic [1:0] c2,
  output logic       x_win,
  output logic       o_win
);

  always_comb begin
    x_win = (c0 == CELL_X) && (c1 == CELL_X) && (c2 == CELL_X);
    o_win = (c0 == CELL_O) && (c1 == CELL_O) && (c2 == CELL_O);
  end

endmodule

// File: rtl/win_checker.sv
// win_checker: reads the nine board cells from the action RAM on `start`,
// then evaluates the eight tic-tac-toe lines.
// Parameters:
//   BASE_ADDR    : RAM address of cell 0 (cells row-major, cell k at BASE_ADDR+k)
//   READ_LATENCY : edges from address sampled by the RAM to d_in valid (>= 1)
// Ports:
//   clock, reset  : system clock; asynchronous active-high reset
//   start         : request a board check (sampled only when idle)
//   read_address  : registered RAM read address
//   d_in          : RAM read data
//   busy          : high from start acceptance until done
//   done          : one-cycle pulse when results update
//   winner        : 00 none, 01 X, 10 O, 11 both
//   win_line      : lowest winning line (0-2 rows, 3-5 cols, 6/7 diags), 15 none
//   draw          : no winner and board full
//   illegal       : corrupt board report (only with WIN_CHECK_ILLEGAL_EN defined,
//                   otherwise tied low)
module win_checker
  import win_checker_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR    = 16'd0,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic [15:0] read_address,
  input  logic [15:0] d_in,
  output logic        busy,
  output logic        done,
  output logic [1:0]  winner,
  output logic [3:0]  win_line,
  output logic        draw,
  output logic        illegal
);

  state_t                  state_q, state_d;
  logic [15:0]             addr_q, addr_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [1:0]              winner_q, winner_d;
  logic [3:0]              win_line_q, win_line_d;
  logic                    draw_q, draw_d;
  logic [3:0]              issue_cnt_q, issue_cnt_d;
  logic [3:0]              cap_cnt_q, cap_cnt_d;
  logic [READ_LATENCY-1:0] pipe_q, pipe_d;
  cell_t                   cells_q [NUM_CELLS];
  cell_t                   cells_d [NUM_CELLS];

  logic                    issued;
  logic [NUM_LINES-1:0]    x_win, o_win;
  logic [3:0]              x_line, o_line;
  logic                    board_full;
  logic [1:0]              eval_winner;
  logic [3:0]              eval_line;
  logic                    eval_draw;

  // ---------------------------------------------------------------------------
  // Line evaluation over the captured snapshot
  // ---------------------------------------------------------------------------
  for (genvar l = 0; l < NUM_LINES; l++) begin : g_line
    win_line_eval u_line (
      .c0    (cells_q[LINE_TBL[l][0]]),
      .c1    (cells_q[LINE_TBL[l][1]]),
      .c2    (cells_q[LINE_TBL[l][2]]),
      .x_win (x_win[l]),
      .o_win (o_win[l])
    );
  end

  always_comb begin
    x_line     = WIN_LINE_NONE;
    o_line     = WIN_LINE_NONE;
    board_full = 1'b1;
    // Walk downwards so the lowest-indexed winning line is the one kept
    for (int unsigned l = NUM_LINES; l > 0; l--) begin
      if (x_win[l-1]) x_line = 4'(l - 1);
      if (o_win[l-1]) o_line = 4'(l - 1);
    end
    for (int unsigned k = 0; k < NUM_CELLS; k++) begin
      if (cells_q[k] == CELL_EMPTY) board_full = 1'b0;
    end
    eval_winner = {|o_win, |x_win};
    // With both players winning the X line is reported
    eval_line   = (|x_win) ? x_line : o_line;
    eval_draw   = !(|x_win) && !(|o_win) && board_full;
  end

`ifdef WIN_CHECK_ILLEGAL_EN
  logic       bad_q, bad_d;
  logic       illegal_q, illegal_d;
  logic [3:0] x_cnt, o_cnt;
  logic       eval_illegal;

  always_comb begin
    x_cnt = '0;
    o_cnt = '0;
    for (int unsigned k = 0; k < NUM_CELLS; k++) begin
      x_cnt = x_cnt + 4'(cells_q[k] == CELL_X);
      o_cnt = o_cnt + 4'(cells_q[k] == CELL_O);
    end
    eval_illegal = bad_q
                || !((x_cnt == o_cnt) || (x_cnt == o_cnt + 4'd1))
                || (eval_winner == WIN_BOTH);
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Fetch / evaluate sequencing
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    winner_d    = winner_q;
    win_line_d  = win_line_q;
    draw_d      = draw_q;
    issue_cnt_d = issue_cnt_q;
    cap_cnt_d   = cap_cnt_q;
    pipe_d      = pipe_q;
    cells_d     = cells_q;
    issued      = 1'b0;
`ifdef WIN_CHECK_ILLEGAL_EN
    bad_d       = bad_q;
    illegal_d   = illegal_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_FETCH;
          busy_d      = 1'b1;
          addr_d      = BASE_ADDR;
          issue_cnt_d = '0;
          cap_cnt_d   = '0;
          pipe_d      = '0;
`ifdef WIN_CHECK_ILLEGAL_EN
          bad_d       = 1'b0;
`endif
        end
      end

      ST_FETCH: begin
        // The address on the bus is sampled by the RAM at this edge; it counts
        // as a request only while cells remain to be fetched.
        issued = (issue_cnt_q < 4'(NUM_CELLS));
        if (issued) begin
          issue_cnt_d = issue_cnt_q + 4'd1;
          if (issue_cnt_q < 4'(NUM_CELLS - 1)) addr_d = addr_q + 16'd1;
        end
        // Each request's data arrives READ_LATENCY edges after issue; the
        // shift register tags which edges carry valid data, decoupling capture
        // from the address counter.
        pipe_d = READ_LATENCY'({pipe_q, issued});
        if (pipe_q[READ_LATENCY-1]) begin
          cells_d[cap_cnt_q] = decode_cell(d_in);
`ifdef WIN_CHECK_ILLEGAL_EN
          if (!is_valid_word(d_in)) bad_d = 1'b1;
`endif
          cap_cnt_d = cap_cnt_q + 4'd1;
          if (cap_cnt_q == 4'(NUM_CELLS - 1)) state_d = ST_EVAL;
        end
      end

      ST_EVAL: begin
        winner_d   = eval_winner;
        win_line_d = eval_line;
        draw_d     = eval_draw;
`ifdef WIN_CHECK_ILLEGAL_EN
        illegal_d  = eval_illegal;
`endif
        done_d     = 1'b1;
        busy_d     = 1'b0;
        addr_d     = BASE_ADDR;
        state_d    = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= BASE_ADDR;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      winner_q    <= WIN_NONE;
      win_line_q  <= WIN_LINE_NONE;
      draw_q      <= 1'b0;
      issue_cnt_q <= '0;
      cap_cnt_q   <= '0;
      pipe_q      <= '0;
      for (int unsigned k = 0; k < NUM_CELLS; k++) cells_q[k] <= CELL_EMPTY;
`ifdef WIN_CHECK_ILLEGAL_EN
      bad_q       <= 1'b0;
      illegal_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      winner_q    <= winner_d;
      win_line_q  <= win_line_d;
      draw_q      <= draw_d;
      issue_cnt_q <= issue_cnt_d;
      cap_cnt_q   <= cap_cnt_d;
      pipe_q      <= pipe_d;
      cells_q     <= cells_d;
`ifdef WIN_CHECK_ILLEGAL_EN
      bad_q       <= bad_d;
      illegal_q   <= illegal_d;
`endif
    end
  end

  assign read_address = addr_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign winner       = winner_q;
  assign win_line     = win_line_q;
  assign draw         = draw_q;

endmodule

// File: tb/tb_win_checker.sv
// Testbench for win_checker: two instances (default base/latency and
// BASE_ADDR=16 / READ_LATENCY=2) fed from a shared RAM model.
module tb_win_checker;

  typedef logic [15:0] board_t [9];

  typedef struct {
    logic [15:0] b [9];
    logic [1:0]  w;
    logic [3:0]  line;
    logic        dr;
    logic        il_en;   // expected illegal when the optional check is built
  } vec_t;

  typedef struct {
    logic [1:0] w;
    logic [3:0] line;
    logic       dr;
    logic       il;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start1, start2;
  logic [15:0] addr1, addr2, d1, d2, d2a;
  logic        busy1, busy2, done1, done2, draw1, draw2, ill1, ill2;
  logic [1:0]  win1, win2;
  logic [3:0]  line1, line2;

  logic [15:0] mem [0:31];
  logic [15:0] addr_log [0:9];

  // Registered RAM read ports: one stage for dut1, two stages for dut2
  always @(posedge clk) begin
    d1  <= mem[addr1[4:0]];
    d2a <= mem[addr2[4:0]];
    d2  <= d2a;
  end

  win_checker #(.BASE_ADDR(16'd0), .READ_LATENCY(1)) dut (
    .clock(clk), .reset(rst), .start(start1), .read_address(addr1), .d_in(d1),
    .busy(busy1), .done(done1), .winner(win1), .win_line(line1), .draw(draw1),
    .illegal(ill1)
  );

  win_checker #(.BASE_ADDR(16'd16), .READ_LATENCY(2)) dut2 (
    .clock(clk), .reset(rst), .start(start2), .read_address(addr2), .d_in(d2),
    .busy(busy2), .done(done2), .winner(win2), .win_line(line2), .draw(draw2),
    .illegal(ill2)
  );

  int n_pass = 0;
  int n_total = 0;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Reference: each line is checked directly from the board rules
  function automatic res_t ref_eval(input board_t b);
    res_t r;
    int owner [9];
    int cl [3];
    int nx = 0, no = 0, xl = -1, ol = -1;
    bit bad = 0, full = 1;
    for (int k = 0; k < 9; k++) begin
      owner[k] = (b[k] == 16'h0001) ? 1 : (b[k] == 16'h0002) ? 2 : 0;
      if (b[k] > 16'h0002) bad = 1;
      if (owner[k] == 1) nx++;
      if (owner[k] == 2) no++;
      if (owner[k] == 0) full = 0;
    end
    for (int l = 0; l < 8; l++) begin
      if (l < 3)       cl = '{3*l, 3*l+1, 3*l+2};
      else if (l < 6)  cl = '{l-3, l, l+3};
      else if (l == 6) cl = '{0, 4, 8};
      else             cl = '{2, 4, 6};
      if (owner[cl[0]] != 0 && owner[cl[0]] == owner[cl[1]] && owner[cl[1]] == owner[cl[2]]) begin
        if (owner[cl[0]] == 1 && xl < 0) xl = l;
        if (owner[cl[0]] == 2 && ol < 0) ol = l;
      end
    end
    r.w    = {ol >= 0, xl >= 0};
    r.line = (xl >= 0) ? 4'(xl) : (ol >= 0) ? 4'(ol) : 4'd15;
    r.dr   = (xl < 0) && (ol < 0) && full;
`ifdef WIN_CHECK_ILLEGAL_EN
    r.il   = bad || !((nx - no == 0) || (nx - no == 1)) || (xl >= 0 && ol >= 0);
`else
    r.il   = 1'b0;
`endif
    return r;
  endfunction

  task automatic add_vec(input board_t b, input logic [1:0] w, input logic [3:0] line,
                         input logic dr, input logic il_en);
    vec_t v;
    v.b = b; v.w = w; v.line = line; v.dr = dr; v.il_en = il_en;
    vecs.push_back(v);
  endtask

  task automatic load(input int base, input board_t b);
    for (int k = 0; k < 9; k++) mem[base + k] = b[k];
  endtask

  // Start one check on the chosen instance; watch 20 cycles after E0.
  // done_n is the edge index n such that done is seen after E_n (-1: never).
  task automatic run_check(input int which, input board_t b,
                           output int done_n, output int ndone, output logic busy0);
    load((which == 1) ? 0 : 16, b);
    @(negedge clk);
    if (which == 1) start1 = 1'b1; else start2 = 1'b1;
    @(posedge clk);
    done_n = -1; ndone = 0; busy0 = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (n == 0) begin
        start1 = 1'b0; start2 = 1'b0;
        busy0 = (which == 1) ? busy1 : busy2;
      end
      if (n < 10) addr_log[n] = (which == 1) ? addr1 : addr2;
      if ((which == 1) ? done1 : done2) begin
        ndone++;
        done_n = n;
      end
    end
  endtask

  task automatic check_results1(input string tag, input res_t e);
    check({tag, " winner"},   32'(win1),  32'(e.w));
    check({tag, " win_line"}, 32'(line1), 32'(e.line));
    check({tag, " draw"},     32'(draw1), 32'(e.dr));
    check({tag, " illegal"},  32'(ill1),  32'(e.il));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    board_t b;
    res_t   e;
    int     done_n, ndone, n2;
    logic   busy0, busy12;

    start1 = 1'b0; start2 = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 16'h0000;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst read_address", 32'(addr1), 32'h0);
    check("rst read_address2", 32'(addr2), 32'h10);
    check("rst busy", 32'(busy1), 32'h0);
    check("rst done", 32'(done1), 32'h0);
    e.w = 2'b00; e.line = 4'd15; e.dr = 1'b0; e.il = 1'b0;
    check_results1("rst", e);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors
    b = '{16'h1, 16'h1, 16'h1, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}; add_vec(b, 2'b01, 4'd0, 1'b0, 1'b1);
    b = '{16'h1, 16'h1, 16'h2, 16'h0, 16'h2, 16'h0, 16'h2, 16'h0, 16'h0}; add_vec(b, 2'b10, 4'd7, 1'b0, 1'b1);
    b = '{16'h1, 16'h2, 16'h1, 16'h1, 16'h2, 16'h2, 16'h2, 16'h1, 16'h1}; add_vec(b, 2'b00, 4'd15, 1'b1, 1'b0);
    b = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}; add_vec(b, 2'b00, 4'd15, 1'b0, 1'b0);
    b = '{16'h1, 16'h1, 16'h1, 16'h2, 16'h2, 16'h2, 16'h0, 16'h0, 16'h0}; add_vec(b, 2'b11, 4'd0, 1'b0, 1'b1);
    b = '{16'h1, 16'h0, 16'h2, 16'h1, 16'h0, 16'h2, 16'h0, 16'h0, 16'h2}; add_vec(b, 2'b10, 4'd5, 1'b0, 1'b1);
    b = '{16'h1, 16'h1, 16'h1, 16'h5, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}; add_vec(b, 2'b01, 4'd0, 1'b0, 1'b1);
    b = '{16'h1, 16'h2, 16'h2, 16'h2, 16'h1, 16'h1, 16'h1, 16'h2, 16'h1}; add_vec(b, 2'b01, 4'd6, 1'b0, 1'b0);
    b = '{16'h0101, 16'h1, 16'h1, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}; add_vec(b, 2'b00, 4'd15, 1'b0, 1'b1);

    foreach (vecs[i]) begin
      run_check(1, vecs[i].b, done_n, ndone, busy0);
      check($sformatf("vec%0d busy", i),   32'(busy0), 32'h1);
      check($sformatf("vec%0d done_at", i), 32'(done_n), 32'd11);
      check($sformatf("vec%0d ndone", i),  32'(ndone), 32'd1);
      e.w = vecs[i].w; e.line = vecs[i].line; e.dr = vecs[i].dr;
`ifdef WIN_CHECK_ILLEGAL_EN
      e.il = vecs[i].il_en;
`else
      e.il = 1'b0;
`endif
      check_results1($sformatf("vec%0d", i), e);
    end

    // Results hold while idle
    repeat (5) @(negedge clk);
    check("hold winner", 32'(win1), 32'(vecs[vecs.size()-1].w));
    check("hold busy", 32'(busy1), 32'h0);

    // Random boards against the reference model
    for (int t = 0; t < 24; t++) begin
      for (int k = 0; k < 9; k++) begin
        int r;
        r = $urandom_range(0, 11);
        b[k] = (r < 4) ? 16'h1 : (r < 8) ? 16'h2 : (r < 11) ? 16'h0 : 16'(($urandom_range(3, 255)));
      end
      e = ref_eval(b);
      run_check(1, b, done_n, ndone, busy0);
      check($sformatf("rnd%0d done_at", t), 32'(done_n), 32'd11);
      check_results1($sformatf("rnd%0d", t), e);
    end

    // start pulsed again at E3 while busy: ignored, single done
    b = vecs[0].b;
    load(0, b);
    @(negedge clk); start1 = 1'b1;
    @(posedge clk);
    done_n = -1; ndone = 0;
    for (int n = 0; n < 26; n++) begin
      @(negedge clk);
      start1 = (n == 2);
      if (done1) begin ndone++; if (done_n < 0) done_n = n; end
    end
    check("busy_start done_at", 32'(done_n), 32'd11);
    check("busy_start ndone", 32'(ndone), 32'd1);
    check("busy_start winner", 32'(win1), 32'h1);

    // Reset asserted at E5 of a scan
    b = vecs[1].b;
    load(0, b);
    @(negedge clk); start1 = 1'b1;
    @(posedge clk);
    @(negedge clk); start1 = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst busy", 32'(busy1), 32'h0);
    check("midrst done", 32'(done1), 32'h0);
    check("midrst read_address", 32'(addr1), 32'h0);
    e.w = 2'b00; e.line = 4'd15; e.dr = 1'b0; e.il = 1'b0;
    check_results1("midrst", e);
    @(negedge clk); rst = 1'b0;
    ndone = 0;
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      if (done1 || busy1) ndone++;
    end
    check("midrst no activity", 32'(ndone), 32'd0);

    // start held high: second check begins the cycle after done
    b = vecs[2].b;
    load(0, b);
    @(negedge clk); start1 = 1'b1;
    @(posedge clk);
    done_n = -1; n2 = -1; busy12 = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (n == 12) begin busy12 = busy1; start1 = 1'b0; end
      if (done1) begin
        if (done_n < 0) done_n = n; else if (n2 < 0) n2 = n;
      end
    end
    check("held first done", 32'(done_n), 32'd11);
    check("held busy_e12", 32'(busy12), 32'h1);
    check("held second done", 32'(n2), 32'd23);
    check("held draw", 32'(draw1), 32'h1);

    // BASE_ADDR=16, READ_LATENCY=2: column 1 win for X
    b = '{16'h0, 16'h1, 16'h0, 16'h0, 16'h1, 16'h0, 16'h0, 16'h1, 16'h0};
    e = ref_eval(b);
    run_check(2, b, done_n, ndone, busy0);
    for (int k = 0; k < 10; k++)
      check($sformatf("lat2 addr%0d", k), 32'(addr_log[k]), 32'(16 + ((k > 8) ? 8 : k)));
    check("lat2 busy", 32'(busy0), 32'h1);
    check("lat2 done_at", 32'(done_n), 32'd12);
    check("lat2 ndone", 32'(ndone), 32'd1);
    check("lat2 winner", 32'(win2), 32'h1);
    check("lat2 win_line", 32'(line2), 32'd4);
    check("lat2 draw", 32'(draw2), 32'h0);
    check("lat2 illegal", 32'(ill2), 32'(e.il));
    check("lat2 addr_idle", 32'(addr2), 32'h10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/win_checker.md
Name: win_checker

Overview:
- Sits directly downstream of the board action RAM and consumes its registered read port.
- On `start`, reads the nine board cells at BASE_ADDR..BASE_ADDR+8, one address per cycle.
- Evaluates the 8 tic-tac-toe lines and reports winner / draw / winning line.
- Consumed by the game controller after each move is written.

Parameters:
- BASE_ADDR, 16'd0, RAM address of cell 0; cells are row-major, cell k at BASE_ADDR+k.
- READ_LATENCY, 1, clock edges from read_address sampled by RAM to d_in valid (RAM registers d_out).

Ports:
- clock  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state and outputs
- start  input  1  request a board check; sampled only in IDLE
- read_address  output  16  registered RAM read address
- d_in  input  16  RAM read data (RAM d_out)
- busy  output  1  high from the start acceptance edge until done
- done  output  1  one-cycle pulse when results are updated
- winner  output  2  00 none, 01 X, 10 O, 11 both (corrupt board)
- win_line  output  4  0-2 rows, 3-5 cols, 6 diag 0-4-8, 7 diag 2-4-6, 15 none
- draw  output  1  no winner and all 9 cells occupied
- illegal  output  1  see Optional Feature

Behaviour:
- Interface: one clock (`clock`); reset (`reset`) is asynchronous, active-high.
- Reset values:
  - read_address=BASE_ADDR; busy=0; done=0; winner=00; win_line=15; draw=0; illegal=0.
  - FSM=IDLE; cell registers cleared to empty.
- Cell encoding: 16'h0001=X, 16'h0002=O, any other value = empty.
- FSM IDLE -> FETCH -> EVAL -> IDLE.
- IDLE:
  - start=1 at edge E0 -> busy=1, read_address=BASE_ADDR, issue counter=0, FSM=FETCH.
- FETCH:
  - read_address increments each edge until BASE_ADDR+8, then holds.
  - Cell k is captured from d_in at edge E(k+1+READ_LATENCY), i.e. E2..E10 for latency 1.
  - The capture counter runs independently of the issue counter.
  - After cell 8 is captured, FSM=EVAL.
- EVAL (one cycle):
  - Results are registered at the next edge (E11): winner, win_line, draw, illegal.
  - done=1 for exactly one cycle, busy=0, FSM=IDLE, read_address returns to BASE_ADDR.
- Line evaluation:
  - A line wins when all three cells are equal and non-empty.
  - win_line reports the lowest-indexed winning line.
  - If both X and O have winning lines, winner=11 and win_line is the lowest X line.
- Outputs winner/win_line/draw/illegal hold until the next EVAL or reset.
- start while busy is ignored (not queued). start held high in IDLE after done starts a new check the cycle after done.
- Reset mid-FETCH: immediate return to IDLE; partial captures discarded; no done.
- Board contents changing during FETCH are not detected; the snapshot is whatever was captured.

Optional Feature:
- Macro: WIN_CHECK_ILLEGAL_EN.
- Defined:
  - illegal=1 if any cell holds a value other than 0000/0001/0002.
  - illegal=1 if count(X)-count(O) is not 0 or 1.
  - illegal=1 if winner=11.
  - Updated at EVAL with the other results.
- Not defined:
  - illegal is tied to 0.
  - Non-0001/0002 values are silently treated as empty; no counting logic is synthesised.

Decomposition:
- Shared package holds:
  - cell codes CELL_EMPTY/CELL_X/CELL_O;
  - winner codes WIN_NONE/WIN_X/WIN_O/WIN_BOTH;
  - WIN_LINE_NONE=4'd15;
  - the 8x3 line-to-cell index table;
  - NUM_CELLS=9.
- One sub-module: win_line_eval, combinational. Inputs: three 2-bit cells. Outputs: x_win, o_win. Instantiated 8 times.

Test Plan:
- Row win: RAM[0..2]=0001, others 0 (default base) -> start at E0 -> done pulse after E11, winner=01, win_line=0, draw=0.
- Diagonal win for O: RAM[2]=RAM[4]=RAM[6]=0002, RAM[0]=RAM[1]=0001 -> winner=10, win_line=7.
- Full-board draw: X,O,X / X,O,O / O,X,X -> winner=00, win_line=15, draw=1.
- Start ignored while busy, then reset mid-scan: pulse start at E0 and E3 -> single done after E11; separate run with reset asserted at E5 -> busy=0 immediately, no done, outputs at reset values.
- Latency and base: BASE_ADDR=16, READ_LATENCY=2, column 1 X win at RAM[17],[20],[23] -> read_address sequence 16..24, done after E12, win_line=4.
- Illegal (macro on): RAM[3]=0005, RAM[0..2]=0001 -> winner=01, illegal=1. Macro off: same board -> illegal=0.
